// File: rtl/pkt_xfer_ctrl.sv
// pkt_xfer_ctrl: sequences the shift buffer, packet register, SPI slave and
// TX buffer. The RX engine hands a packet to SPI one byte per chip-select
// frame. The TX engine serialises SPI-supplied bytes into the TX buffer.
// Every output is registered. Each output is computed from next-state logic,
// so it follows the qualifying input by exactly one clock.
module pkt_xfer_ctrl #(
  parameter int PKT_BYTES = 3,
  parameter int TX_BYTES  = 1,
  parameter int BYTE_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_mode,
  input  logic       pkt_rec,
  input  logic       cs_sync,
  input  logic       spi_out_rdy,
  input  logic       sh_en,
  input  logic       sh_en_done,
  output logic       pkt_ld,
  output logic       spi_ld,
  output logic       pkt_en,
  output logic       pkt_rst,
  output logic       tx_ld,
  output logic       tx_sh,
  output logic       tx_en,
  output logic [3:0] byte_idx,
  output logic       rx_ovf,
  output logic       busy
);

  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_WAIT, R_XFER} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_ARM, T_SHIFT} tx_state_t;

  localparam logic [3:0] PKT_N = 4'(PKT_BYTES);
  localparam logic [3:0] TX_N  = 4'(TX_BYTES);
  localparam logic [3:0] BW_N  = 4'(BYTE_W);

  rx_state_t  rx_state_reg, rx_state_next;
  tx_state_t  tx_state_reg, tx_state_next;
  logic       pkt_rec_q;
  logic [3:0] rx_rem_reg, rx_rem_next;
  logic [3:0] rx_idx_reg, rx_idx_next;
  logic       rx_ovf_next;
  logic [3:0] tx_bitcnt_reg, tx_bitcnt_next;
  logic [3:0] tx_idx_reg, tx_idx_next;
  logic [3:0] tx_idx_inc;
  logic       tx_byte_done;
  logic       rec_edge;
  logic       pkt_ld_next, spi_ld_next, pkt_en_next, pkt_rst_next;
  logic       tx_ld_next, tx_sh_next, tx_en_next;
  logic [3:0] byte_idx_next;
  logic       busy_next;

  assign rec_edge     = pkt_rec & ~pkt_rec_q;
  assign tx_byte_done = (tx_bitcnt_reg >= BW_N) || sh_en_done;
  assign tx_idx_inc   = (tx_idx_reg < TX_N) ? tx_idx_reg + 4'd1 : tx_idx_reg;

  // RX engine next-state: forced idle (and flags cleared) while TX mode is selected.
  always_comb begin
    rx_state_next = rx_state_reg;
    rx_rem_next   = rx_rem_reg;
    rx_idx_next   = rx_idx_reg;
    rx_ovf_next   = rx_ovf;
    pkt_ld_next   = 1'b0;
    spi_ld_next   = 1'b0;
    pkt_en_next   = 1'b0;
    pkt_rst_next  = 1'b0;
    if (!rx_mode) begin
      rx_state_next = R_IDLE;
      rx_rem_next   = 4'd0;
      rx_idx_next   = 4'd0;
      rx_ovf_next   = 1'b0;
    end else begin
      // A packet arriving while a transfer is in flight is dropped and flagged.
      if (rec_edge && rx_state_reg != R_IDLE) rx_ovf_next = 1'b1;
      case (rx_state_reg)
        R_IDLE: if (rec_edge) begin
          rx_state_next = R_LOAD;
          pkt_ld_next   = 1'b1;
          spi_ld_next   = 1'b1;
          rx_rem_next   = PKT_N;
          rx_idx_next   = 4'd0;
        end
        R_LOAD: begin
          pkt_rst_next  = 1'b1;
          rx_state_next = R_WAIT;
        end
        R_WAIT: if (!cs_sync) rx_state_next = R_XFER;
        R_XFER: if (cs_sync) begin
          pkt_en_next   = 1'b1;
          rx_rem_next   = (rx_rem_reg != 4'd0) ? rx_rem_reg - 4'd1 : 4'd0;
          rx_idx_next   = (rx_idx_reg < PKT_N) ? rx_idx_reg + 4'd1 : rx_idx_reg;
          rx_state_next = (rx_rem_reg <= 4'd1) ? R_IDLE : R_WAIT;
        end
        default: rx_state_next = R_IDLE;
      endcase
    end
  end

  // TX engine next-state: forced idle while RX mode is selected.
  always_comb begin
    tx_state_next  = tx_state_reg;
    tx_bitcnt_next = tx_bitcnt_reg;
    tx_idx_next    = tx_idx_reg;
    tx_ld_next     = 1'b0;
    tx_en_next     = 1'b0;
    if (rx_mode) begin
      tx_state_next  = T_IDLE;
      tx_bitcnt_next = 4'd0;
      tx_idx_next    = 4'd0;
    end else begin
      case (tx_state_reg)
        T_IDLE: if (!cs_sync) begin
          tx_state_next = T_ARM;
          tx_idx_next   = 4'd0;
        end
        T_ARM: if (spi_out_rdy) begin
          tx_ld_next     = 1'b1;
          tx_bitcnt_next = 4'd0;
          tx_state_next  = T_SHIFT;
        end
        T_SHIFT: begin
          // Byte completion takes priority over a coincident shift strobe.
          if (tx_byte_done) begin
            tx_idx_next   = tx_idx_inc;
            tx_state_next = (tx_idx_inc >= TX_N || sh_en_done) ? T_IDLE : T_ARM;
          end else if (sh_en) begin
            tx_en_next     = 1'b1;
            tx_bitcnt_next = tx_bitcnt_reg + 4'd1;
          end
        end
        default: tx_state_next = T_IDLE;
      endcase
    end
  end

  // Shared status outputs follow whichever engine is selected.
  always_comb begin
    tx_sh_next    = (tx_state_next == T_SHIFT);
    byte_idx_next = rx_mode ? rx_idx_next : tx_idx_next;
    busy_next     = rx_mode ? (rx_state_next != R_IDLE) : (tx_state_next != T_IDLE);
  end

  // State, counter and registered-output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_reg  <= R_IDLE;
      tx_state_reg  <= T_IDLE;
      pkt_rec_q     <= 1'b0;
      rx_rem_reg    <= 4'd0;
      rx_idx_reg    <= 4'd0;
      tx_bitcnt_reg <= 4'd0;
      tx_idx_reg    <= 4'd0;
      pkt_ld        <= 1'b0;
      spi_ld        <= 1'b0;
      pkt_en        <= 1'b0;
      pkt_rst       <= 1'b0;
      tx_ld         <= 1'b0;
      tx_sh         <= 1'b0;
      tx_en         <= 1'b0;
      byte_idx      <= 4'd0;
      rx_ovf        <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rx_state_reg  <= rx_state_next;
      tx_state_reg  <= tx_state_next;
      pkt_rec_q     <= pkt_rec;
      rx_rem_reg    <= rx_rem_next;
      rx_idx_reg    <= rx_idx_next;
      tx_bitcnt_reg <= tx_bitcnt_next;
      tx_idx_reg    <= tx_idx_next;
      pkt_ld        <= pkt_ld_next;
      spi_ld        <= spi_ld_next;
      pkt_en        <= pkt_en_next;
      pkt_rst       <= pkt_rst_next;
      tx_ld         <= tx_ld_next;
      tx_sh         <= tx_sh_next;
      tx_en         <= tx_en_next;
      byte_idx      <= byte_idx_next;
      rx_ovf        <= rx_ovf_next;
      busy          <= busy_next;
    end
  end

endmodule

// File: tb/tb_pkt_xfer_ctrl.sv
// Directed testbench for pkt_xfer_ctrl (PKT_BYTES=3, TX_BYTES=2, BYTE_W=8).
module tb_pkt_xfer_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_mode = 1'b1;
  logic       pkt_rec = 1'b0;
  logic       cs_sync = 1'b1;
  logic       spi_out_rdy = 1'b0;
  logic       sh_en = 1'b0;
  logic       sh_en_done = 1'b0;
  logic       pkt_ld, spi_ld, pkt_en, pkt_rst, tx_ld, tx_sh, tx_en, rx_ovf, busy;
  logic [3:0] byte_idx;

  int checks = 0;
  int errors = 0;
  int pkt_ld_cnt = 0, pkt_en_cnt = 0, tx_ld_cnt = 0, tx_en_cnt = 0;
  int base_ld, base_en, base_txld, base_txen;

  pkt_xfer_ctrl #(.PKT_BYTES(3), .TX_BYTES(2), .BYTE_W(8)) dut (
    .clk(clk), .rst(rst), .rx_mode(rx_mode), .pkt_rec(pkt_rec), .cs_sync(cs_sync),
    .spi_out_rdy(spi_out_rdy), .sh_en(sh_en), .sh_en_done(sh_en_done),
    .pkt_ld(pkt_ld), .spi_ld(spi_ld), .pkt_en(pkt_en), .pkt_rst(pkt_rst),
    .tx_ld(tx_ld), .tx_sh(tx_sh), .tx_en(tx_en), .byte_idx(byte_idx),
    .rx_ovf(rx_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (pkt_ld === 1'b1) pkt_ld_cnt++;
    if (pkt_en === 1'b1) pkt_en_cnt++;
    if (tx_ld === 1'b1)  tx_ld_cnt++;
    if (tx_en === 1'b1)  tx_en_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_pkt_ld", pkt_ld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_byte_idx", byte_idx, 0);
    chk("rst_rx_ovf", rx_ovf, 0);
    chk("rst_tx_sh", tx_sh, 0);
    rst = 1'b0;
    tick();

    // RX: one packet, three CS frames
    base_ld = pkt_ld_cnt; base_en = pkt_en_cnt;
    pkt_rec = 1'b1; tick();
    chk("rx_pkt_ld", pkt_ld, 1);
    chk("rx_spi_ld", spi_ld, 1);
    chk("rx_busy", busy, 1);
    chk("rx_idx0", byte_idx, 0);
    chk("rx_no_rst_yet", pkt_rst, 0);
    tick();
    chk("rx_pkt_ld_drop", pkt_ld, 0);
    chk("rx_pkt_rst", pkt_rst, 1);
    tick();
    chk("rx_pkt_rst_drop", pkt_rst, 0);
    for (int i = 0; i < 3; i++) begin
      cs_sync = 1'b0; tick();
      chk("rx_no_en_cs_low", pkt_en, 0);
      cs_sync = 1'b1; tick();
      chk("rx_pkt_en", pkt_en, 1);
      chk("rx_idx", byte_idx, i + 1);
      chk("rx_busy_frame", busy, (i < 2) ? 1 : 0);
      tick();
      chk("rx_pkt_en_drop", pkt_en, 0);
    end
    chk("rx_pkt_en_total", pkt_en_cnt - base_en, 3);
    chk("rx_pkt_ld_total", pkt_ld_cnt - base_ld, 1);
    pkt_rec = 1'b0; tick();

    // RX overrun: second packet edge during first CS frame
    base_ld = pkt_ld_cnt; base_en = pkt_en_cnt;
    pkt_rec = 1'b1; tick();
    pkt_rec = 1'b0; tick(); tick();
    cs_sync = 1'b0; tick();
    chk("ovf_clear_before", rx_ovf, 0);
    pkt_rec = 1'b1; tick();
    chk("ovf_set", rx_ovf, 1);
    for (int i = 0; i < 3; i++) begin
      cs_sync = 1'b0; tick();
      cs_sync = 1'b1; tick();
    end
    tick(); tick();
    chk("ovf_pkt_ld_total", pkt_ld_cnt - base_ld, 1);
    chk("ovf_pkt_en_total", pkt_en_cnt - base_en, 3);
    chk("ovf_hold", rx_ovf, 1);
    chk("ovf_idle", busy, 0);
    chk("ovf_idx", byte_idx, 3);

    // Mode switch while RX waits for CS: RX abandoned, no pkt_en
    pkt_rec = 1'b0; tick();
    pkt_rec = 1'b1; tick(); tick(); tick();
    chk("sw_busy_wait", busy, 1);
    base_en = pkt_en_cnt;
    rx_mode = 1'b0; tick();
    chk("sw_busy", busy, 0);
    chk("sw_ovf_clear", rx_ovf, 0);
    tick(); tick();
    chk("sw_no_pkt_en", pkt_en_cnt - base_en, 0);
    pkt_rec = 1'b0;

    // TX: two bytes of eight bits
    base_txld = tx_ld_cnt; base_txen = tx_en_cnt;
    cs_sync = 1'b0; tick();
    chk("tx_arm_busy", busy, 1);
    chk("tx_arm_idx", byte_idx, 0);
    cs_sync = 1'b1;
    for (int b = 0; b < 2; b++) begin
      spi_out_rdy = 1'b1; tick();
      spi_out_rdy = 1'b0;
      chk("tx_ld", tx_ld, 1);
      chk("tx_sh", tx_sh, 1);
      for (int k = 0; k < 8; k++) begin
        sh_en = 1'b1; tick();
        chk("tx_en", tx_en, 1);
      end
      sh_en = 1'b0; tick();
      chk("tx_sh_done", tx_sh, 0);
      chk("tx_en_done", tx_en, 0);
      chk("tx_idx", byte_idx, b + 1);
      chk("tx_busy", busy, (b == 0) ? 1 : 0);
    end
    tick();
    chk("tx_ld_total", tx_ld_cnt - base_txld, 2);
    chk("tx_en_total", tx_en_cnt - base_txen, 16);

    // TX early abort; sh_en coinciding with sh_en_done gives no tx_en
    base_txen = tx_en_cnt;
    cs_sync = 1'b0; tick();
    chk("ab_idx0", byte_idx, 0);
    cs_sync = 1'b1; spi_out_rdy = 1'b1; tick();
    spi_out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sh_en = 1'b1; tick();
    end
    sh_en_done = 1'b1; tick();
    sh_en = 1'b0; sh_en_done = 1'b0;
    chk("ab_tx_en", tx_en, 0);
    chk("ab_tx_sh", tx_sh, 0);
    chk("ab_busy", busy, 0);
    chk("ab_idx", byte_idx, 1);
    tick();
    chk("ab_tx_en_total", tx_en_cnt - base_txen, 3);

    // Asynchronous reset during shifting
    cs_sync = 1'b0; tick();
    cs_sync = 1'b1; spi_out_rdy = 1'b1; tick();
    spi_out_rdy = 1'b0;
    sh_en = 1'b1; tick();
    chk("rs_tx_sh_pre", tx_sh, 1);
    chk("rs_tx_en_pre", tx_en, 1);
    sh_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rs_tx_sh", tx_sh, 0);
    chk("rs_tx_en", tx_en, 0);
    chk("rs_busy", busy, 0);
    tick();
    rst = 1'b0;
    base_txld = tx_ld_cnt;
    spi_out_rdy = 1'b1; tick(); tick();
    spi_out_rdy = 1'b0;
    chk("rs_idle_busy", busy, 0);
    chk("rs_no_tx_ld", tx_ld_cnt - base_txld, 0);
    chk("rs_idx", byte_idx, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
